// File: rtl/csi_rx_pkt_ctrl_pkg.sv
// csi_rx_pkt_ctrl_pkg: shared types and constants for the CSI-2 receive packet controller.
package csi_rx_pkt_ctrl_pkg;
    localparam int NUM_LANE = 4;
    localparam logic [5:0] CSI_SHORT_DT_MAX = 6'h0F;
    typedef logic [NUM_LANE*8-1:0] lane_data_t;
    typedef enum logic [5:0] {
        DT_FS    = 6'h00,
        DT_FE    = 6'h01,
        DT_LS    = 6'h02,
        DT_LE    = 6'h03,
        DT_RAW8  = 6'h2A,
        DT_RAW10 = 6'h2B
    } csi_dt_e;
    typedef struct packed {
        logic [7:0]  ecc;
        logic [15:0] wc;
        logic [7:0]  di;
    } csi_hdr_t;
    typedef enum logic [1:0] {SYNC_WAIT, HDR, PAYLOAD, DONE} pkt_state_e;
    // Parity masks of the CSI-2 header ECC, bit i of the ECC covers the set bits of mask i
    localparam logic [23:0] ECC_MASK [6] = '{
        24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00
    };
endpackage

// File: rtl/csi_rx_hdr_ecc.sv
// csi_rx_hdr_ecc: combinational 6-bit CSI-2 packet header ECC generator.
module csi_rx_hdr_ecc
    import csi_rx_pkt_ctrl_pkg::*;
(
    input  logic [23:0] data,
    output logic [5:0]  ecc
);
    for (genvar g = 0; g < 6; g++) begin : g_par
        assign ecc[g] = ^(data & ECC_MASK[g]);
    end
endmodule

// File: rtl/csi_rx_pkt_ctrl.sv
// csi_rx_pkt_ctrl: CSI-2 packet parser/sequencer after the word aligner.
// Header ECC checking is built in when CSI_RX_ECC_CHECK_EN is defined.
module csi_rx_pkt_ctrl
    import csi_rx_pkt_ctrl_pkg::*;
#(
    parameter int         NUM_LANE  = csi_rx_pkt_ctrl_pkg::NUM_LANE,
    parameter logic [1:0] VC_FILTER = 2'd0
) (
    input  logic                  byte_clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  word_valid,
    input  logic [NUM_LANE*8-1:0] word_data,
    output logic                  wait_for_sync,
    output logic                  packet_done,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  line_start,
    output logic                  line_end,
    output logic                  pix_valid,
    output logic [NUM_LANE*8-1:0] pix_data,
    output logic [NUM_LANE-1:0]   pix_byte_en,
    output logic [5:0]            pix_dt,
    output logic                  pkt_err
);
    localparam logic [16:0] NL = 17'(NUM_LANE);
    pkt_state_e state, state_d;
    logic [7:0] di_q, di_d, wc_lo_q, wc_lo_d;
    logic [15:0] wc_q, wc_d;
    logic [16:0] rem, rem_d, cnt, cnt_d;
    logic [1:0] vc_q, vc_d;
    logic err_q, err_d, wfs_d, done_d, perr_d, pv_d, hdr_end, long_pkt, ecc_ok;
    logic [3:0] strb_d;
    logic [5:0] dt_d;
    logic [NUM_LANE*8-1:0] pd_d;
    logic [NUM_LANE-1:0] be, be_d;
    csi_hdr_t hdr;

    // 4 lanes deliver the whole header in one word; 2 lanes complete it from the HDR word
    if (NUM_LANE == 4) begin : g_hdr4
        logic unused_hdr;
        assign hdr = word_data[31:0];
        assign unused_hdr = ^{di_q, wc_lo_q};
    end else begin : g_hdr2
        assign hdr = {word_data[15:0], wc_lo_q, di_q};
    end

`ifdef CSI_RX_ECC_CHECK_EN
    logic [5:0] ecc_calc;
    logic unused_ecc;
    csi_rx_hdr_ecc u_ecc (.data(hdr[23:0]), .ecc(ecc_calc));
    assign ecc_ok = ecc_calc == hdr.ecc[5:0];
    assign unused_ecc = ^hdr.ecc[7:6];
`else
    logic unused_ecc;
    assign ecc_ok = 1'b1;
    assign unused_ecc = ^hdr.ecc;
`endif

    assign hdr_end = word_valid && ((state == SYNC_WAIT && NUM_LANE == 4) || state == HDR);
    assign long_pkt = hdr.di[5:0] > CSI_SHORT_DT_MAX;

    always_comb begin
        for (int i = 0; i < NUM_LANE; i++) be[i] = (cnt + 17'(i)) < {1'b0, wc_q};
    end

    always_comb begin
        state_d = state;
        di_d = di_q;
        wc_lo_d = wc_lo_q;
        wc_d = wc_q;
        rem_d = rem;
        cnt_d = cnt;
        vc_d = vc_q;
        err_d = err_q;
        dt_d = pix_dt;
        wfs_d = 1'b0;
        done_d = 1'b0;
        perr_d = 1'b0;
        strb_d = '0;
        pv_d = 1'b0;
        pd_d = '0;
        be_d = '0;
        case (state)
            SYNC_WAIT: begin
                wfs_d = !word_valid;
                err_d = 1'b0;
                if (word_valid) begin
                    state_d = HDR;
                    di_d = word_data[7:0];
                    wc_lo_d = word_data[15:8];
                end
            end
            HDR: if (!word_valid) begin
                state_d = DONE;
                err_d = 1'b1;
            end
            PAYLOAD: if (!word_valid) begin
                state_d = DONE;
                err_d = 1'b1;
            end else begin
                rem_d = (rem > NL) ? rem - NL : '0;
                cnt_d = cnt + NL;
                pv_d = |be && vc_q == VC_FILTER;
                pd_d = pv_d ? word_data : '0;
                be_d = pv_d ? be : '0;
                state_d = (rem <= NL) ? DONE : PAYLOAD;
            end
            default: begin
                done_d = 1'b1;
                perr_d = err_q;
                state_d = SYNC_WAIT;
            end
        endcase
        if (hdr_end) begin
            if (!ecc_ok) begin
                state_d = DONE;
                err_d = 1'b1;
            end else if (!long_pkt) begin
                state_d = DONE;
                strb_d = {hdr.di[5:0] == DT_FS, hdr.di[5:0] == DT_FE, hdr.di[5:0] == DT_LS, hdr.di[5:0] == DT_LE};
            end else begin
                state_d = PAYLOAD;
                rem_d = {1'b0, hdr.wc} + 17'd2;
                wc_d = hdr.wc;
                cnt_d = '0;
                vc_d = hdr.di[7:6];
                dt_d = hdr.di[5:0];
            end
        end
    end

    // Disabling behaves like reset: silent return to sync hunt, no done/err pulse
    always_ff @(posedge byte_clock) begin
        if (!reset_n || !enable) begin
            state <= SYNC_WAIT;
            di_q <= '0;
            wc_lo_q <= '0;
            wc_q <= '0;
            rem <= '0;
            cnt <= '0;
            vc_q <= '0;
            err_q <= 1'b0;
            wait_for_sync <= 1'b1;
            packet_done <= 1'b0;
            pkt_err <= 1'b0;
            {frame_start, frame_end, line_start, line_end} <= '0;
            pix_valid <= 1'b0;
            pix_data <= '0;
            pix_byte_en <= '0;
            pix_dt <= '0;
        end else begin
            state <= state_d;
            di_q <= di_d;
            wc_lo_q <= wc_lo_d;
            wc_q <= wc_d;
            rem <= rem_d;
            cnt <= cnt_d;
            vc_q <= vc_d;
            err_q <= err_d;
            wait_for_sync <= wfs_d;
            packet_done <= done_d;
            pkt_err <= perr_d;
            {frame_start, frame_end, line_start, line_end} <= strb_d;
            pix_valid <= pv_d;
            pix_data <= pd_d;
            pix_byte_en <= be_d;
            pix_dt <= dt_d;
        end
    end
endmodule

// File: tb/tb_csi_rx_pkt_ctrl.sv
// tb_csi_rx_pkt_ctrl: directed vectors for 4-lane and 2-lane csi_rx_pkt_ctrl instances.
module tb_csi_rx_pkt_ctrl;
    localparam logic [7:0] W = 8'h80, D = 8'h40, E = 8'h20, FS = 8'h10;
    localparam logic [7:0] FE = 8'h08, LS = 8'h04, LE = 8'h02, PV = 8'h01;
    localparam logic [23:0] M [6] = '{
        24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00
    };
    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic [7:0]  fl;
        logic [3:0]  be;
        logic [5:0]  dt;
        logic [31:0] pd;
    } vec_t;

    logic byte_clock = 1'b0, reset_n = 1'b0, enable = 1'b1, wv4 = 1'b0, wv2 = 1'b0;
    logic [31:0] wd4 = '0;
    logic [15:0] wd2 = '0;
    logic wfs4, done4, fs4, fe4, ls4, le4, pv4, err4;
    logic wfs2, done2, fs2, fe2, ls2, le2, pv2, err2;
    logic [31:0] pd4;
    logic [15:0] pd2;
    logic [3:0] be4;
    logic [1:0] be2;
    logic [5:0] dt4, dt2;
    logic [49:0] o4;
    logic [31:0] o2;
    int n_vec = 0, n_err = 0;
    vec_t tbl[$];

    always #5 byte_clock = ~byte_clock;

    csi_rx_pkt_ctrl #(.NUM_LANE(4), .VC_FILTER(2'd0)) d4 (
        .byte_clock(byte_clock), .reset_n(reset_n), .enable(enable),
        .word_valid(wv4), .word_data(wd4), .wait_for_sync(wfs4), .packet_done(done4),
        .frame_start(fs4), .frame_end(fe4), .line_start(ls4), .line_end(le4),
        .pix_valid(pv4), .pix_data(pd4), .pix_byte_en(be4), .pix_dt(dt4), .pkt_err(err4)
    );
    csi_rx_pkt_ctrl #(.NUM_LANE(2), .VC_FILTER(2'd0)) d2 (
        .byte_clock(byte_clock), .reset_n(reset_n), .enable(enable),
        .word_valid(wv2), .word_data(wd2), .wait_for_sync(wfs2), .packet_done(done2),
        .frame_start(fs2), .frame_end(fe2), .line_start(ls2), .line_end(le2),
        .pix_valid(pv2), .pix_data(pd2), .pix_byte_en(be2), .pix_dt(dt2), .pkt_err(err2)
    );

    assign o4 = {wfs4, done4, err4, fs4, fe4, ls4, le4, pv4, be4, dt4, pd4};
    assign o2 = {wfs2, done2, err2, fs2, fe2, ls2, le2, pv2, be2, dt2, pd2};

    function automatic logic [7:0] ecc(input logic [23:0] d);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 6; i++) e[i] = ^(d & M[i]);
        return e;
    endfunction

    function automatic logic [31:0] h(input logic [7:0] di, input logic [15:0] wc);
        return {ecc({wc, di}), wc, di};
    endfunction

    function automatic void add(input logic wv, input logic [31:0] wd, input logic [7:0] fl,
                                input logic [3:0] be, input logic [5:0] dt, input logic [31:0] pd);
        vec_t v;
        v.wv = wv;
        v.wd = wd;
        v.fl = fl;
        v.be = be;
        v.dt = dt;
        v.pd = pd;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step4(input string nm, input logic wv, input logic [31:0] wd, input logic [7:0] fl,
                         input logic [3:0] be, input logic [5:0] dt, input logic [31:0] pd);
        @(negedge byte_clock);
        wv4 = wv;
        wd4 = wd;
        @(posedge byte_clock);
        #1;
        chk(nm, 64'(o4), 64'({fl, be, dt, pd}));
    endtask

    task automatic step2(input string nm, input logic wv, input logic [15:0] wd, input logic [7:0] fl,
                         input logic [1:0] be, input logic [5:0] dt, input logic [15:0] pd);
        @(negedge byte_clock);
        wv2 = wv;
        wd2 = wd;
        @(posedge byte_clock);
        #1;
        chk(nm, 64'(o2), 64'({fl, be, dt, pd}));
    endtask

    initial begin
        add(1, h(8'h00, 16'd1), FS, 0, 6'h00, 0);
        add(0, 0, D, 0, 6'h00, 0);
        add(0, 0, W, 0, 6'h00, 0);
        add(1, h(8'h2A, 16'd10), 0, 0, 6'h2A, 0);
        add(1, 32'h04030201, PV, 4'hF, 6'h2A, 32'h04030201);
        add(1, 32'h08070605, PV, 4'hF, 6'h2A, 32'h08070605);
        add(1, 32'hCCCC0A09, PV, 4'h3, 6'h2A, 32'hCCCC0A09);
        add(1, 32'hDEADBEEF, D, 0, 6'h2A, 0);
        add(0, 0, W, 0, 6'h2A, 0);
        add(1, h(8'h03, 16'd0), LE, 0, 6'h2A, 0);
        add(0, 0, D, 0, 6'h2A, 0);
        add(0, 0, W, 0, 6'h2A, 0);
        add(1, h(8'h08, 16'd0), 0, 0, 6'h2A, 0);
        add(0, 0, D, 0, 6'h2A, 0);
        add(1, h(8'h01, 16'd0), FE, 0, 6'h2A, 0);
        add(0, 0, D, 0, 6'h2A, 0);
        add(0, 0, W, 0, 6'h2A, 0);
        add(1, h(8'h2B, 16'd0), 0, 0, 6'h2B, 0);
        add(1, 32'h12345678, 0, 0, 6'h2B, 0);
        add(0, 0, D, 0, 6'h2B, 0);
        add(0, 0, W, 0, 6'h2B, 0);
        add(1, h(8'h6A, 16'd4), 0, 0, 6'h2A, 0);
        add(1, 32'h11111111, 0, 0, 6'h2A, 0);
        add(1, 32'h22222222, 0, 0, 6'h2A, 0);
        add(0, 0, D, 0, 6'h2A, 0);
        add(0, 0, W, 0, 6'h2A, 0);
        add(1, h(8'h02, 16'd0), LS, 0, 6'h2A, 0);
        add(0, 0, D, 0, 6'h2A, 0);
        add(0, 0, W, 0, 6'h2A, 0);

        step4("reset4", 0, 0, W, 0, 0, 0);
        step2("reset2", 0, 0, W, 0, 0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++)
            step4($sformatf("vec%0d", i), tbl[i].wv, tbl[i].wd, tbl[i].fl, tbl[i].be, tbl[i].dt, tbl[i].pd);

        step2("l2_hdr0", 1, 16'h052B, 0, 0, 6'h00, 0);
        step2("l2_hdr1", 1, {ecc(24'h00052B), 8'h00}, 0, 0, 6'h2B, 0);
        step2("l2_p1", 1, 16'h0201, PV, 2'b11, 6'h2B, 16'h0201);
        step2("l2_p2", 1, 16'h0403, PV, 2'b11, 6'h2B, 16'h0403);
        step2("l2_p3", 1, 16'hCC05, PV, 2'b01, 6'h2B, 16'hCC05);
        step2("l2_crc", 1, 16'hEEEE, 0, 0, 6'h2B, 0);
        step2("l2_done", 0, 0, D, 0, 6'h2B, 0);
        step2("l2_wfs", 0, 0, W, 0, 6'h2B, 0);

        step4("ab_hdr", 1, h(8'h2A, 16'd64), 0, 0, 6'h2A, 0);
        step4("ab_p1", 1, 32'hA1A2A3A4, PV, 4'hF, 6'h2A, 32'hA1A2A3A4);
        step4("ab_p2", 1, 32'hB1B2B3B4, PV, 4'hF, 6'h2A, 32'hB1B2B3B4);
        step4("ab_gap", 0, 0, 0, 0, 6'h2A, 0);
        step4("ab_done", 0, 0, D | E, 0, 6'h2A, 0);
        step4("ab_wfs", 0, 0, W, 0, 6'h2A, 0);

        step4("ecc_hdr", 1, h(8'h2A, 16'd4) ^ 32'h0800_0000, 0, 0, 6'h2A, 0);
`ifdef CSI_RX_ECC_CHECK_EN
        step4("ecc_err", 0, 0, D | E, 0, 6'h2A, 0);
        step4("ecc_wfs", 0, 0, W, 0, 6'h2A, 0);
`else
        step4("ecc_p1", 1, 32'hAABBCCDD, PV, 4'hF, 6'h2A, 32'hAABBCCDD);
        step4("ecc_crc", 1, 32'h99999999, 0, 0, 6'h2A, 0);
        step4("ecc_done", 0, 0, D, 0, 6'h2A, 0);
        step4("ecc_wfs", 0, 0, W, 0, 6'h2A, 0);
`endif

        step4("en_hdr", 1, h(8'h2A, 16'd64), 0, 0, 6'h2A, 0);
        step4("en_p1", 1, 32'h01020304, PV, 4'hF, 6'h2A, 32'h01020304);
        enable = 1'b0;
        step4("en_off", 1, 32'h05060708, W, 0, 6'h00, 0);
        enable = 1'b1;
        step4("en_idle1", 0, 0, W, 0, 6'h00, 0);
        step4("en_idle2", 0, 0, W, 0, 6'h00, 0);

        step4("rst_hdr", 1, h(8'h2A, 16'd64), 0, 0, 6'h2A, 0);
        step4("rst_p1", 1, 32'h0A0B0C0D, PV, 4'hF, 6'h2A, 32'h0A0B0C0D);
        reset_n = 1'b0;
        step4("rst_mid", 1, 32'h0E0F1011, W, 0, 6'h00, 0);
        reset_n = 1'b1;
        step4("rst_idle1", 0, 0, W, 0, 6'h00, 0);
        step4("rst_idle2", 0, 0, W, 0, 6'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
